// File: rtl/weight_stream_reader_if.sv
// Bundle between one weight BRAM, the stream reader and the neuron MAC:
// BRAM read port plus the valid/ready weight stream.
interface weight_stream_reader_if #(
    parameter int AW = 5,
    parameter int DW = 16
);
    logic [AW-1:0] addr;
    logic          en;
    logic          we;
    logic [DW-1:0] di;
    logic [DW-1:0] do_data;
    logic [DW-1:0] w_data;
    logic          w_valid;
    logic          w_ready;
    logic          w_last;
    logic [AW-1:0] w_index;

    modport master (
        output addr, en, we, di, w_data, w_valid, w_last, w_index,
        input  do_data, w_ready
    );

    modport slave (
        input  addr, en, we, di, w_data, w_valid, w_last, w_index,
        output do_data, w_ready
    );
endinterface

// File: rtl/weight_stream_reader.sv
// Reads every word of a weight BRAM once per start and streams them to the MAC,
// using a credit-limited 2-entry buffer so backpressure never loses a read.
module weight_stream_reader #(
    parameter int DEPTH = 28,
    parameter int AW    = 5,
    parameter int DW    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    output logic                   busy,
    output logic                   done,
    weight_stream_reader_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        state, state_next;
    logic [AW-1:0] issue_cnt, issue_cnt_next;
    logic [AW-1:0] addr_q, addr_next;
    logic          en_q, en_next;
    logic [1:0]    credit, credit_next;
    logic          done_next;
    logic          accept, issue, flush;
    logic [AW-1:0] issue_addr;

    logic [DW-1:0] buf_data  [2];
    logic [AW-1:0] buf_index [2];
    logic          buf_last  [2];
    logic          rd_ptr, wr_ptr;
    logic [1:0]    count;
    logic          push, pop;

    assign pop  = (count != 2'd0) && bus.w_ready;
    // en_q doubles as the in-flight flag: DO for addr_q arrives at the next edge
    assign push = en_q && !flush;

    always_comb begin
        state_next     = state;
        issue_cnt_next = issue_cnt;
        addr_next      = addr_q;
        en_next        = 1'b0;
        credit_next    = credit;
        done_next      = 1'b0;
        flush          = 1'b0;
        accept         = (state == IDLE) && start && !abort && !done;
        issue_addr     = accept ? '0 : issue_cnt;
        issue          = accept || ((state == FETCH) && ((credit != 2'd0) || pop));

        if (issue) begin
            en_next   = 1'b1;
            addr_next = issue_addr;
            if (issue_addr == LAST_ADDR) begin
                state_next = DRAIN;
            end else begin
                state_next     = FETCH;
                issue_cnt_next = issue_addr + AW'(1);
            end
        end
        credit_next = credit - {1'b0, issue} + {1'b0, pop};

        if ((state == DRAIN) && pop && bus.w_last) begin
            state_next = IDLE;
            done_next  = 1'b1;
        end

        if (abort && (state != IDLE)) begin
            state_next     = IDLE;
            issue_cnt_next = issue_cnt;
            addr_next      = addr_q;
            en_next        = 1'b0;
            credit_next    = 2'd2;
            done_next      = 1'b0;
            flush          = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            issue_cnt <= '0;
            addr_q    <= '0;
            en_q      <= 1'b0;
            credit    <= 2'd2;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            issue_cnt <= issue_cnt_next;
            addr_q    <= addr_next;
            en_q      <= en_next;
            credit    <= credit_next;
            done      <= done_next;
        end
    end

    // Credits guarantee a push never meets a full buffer, so no full check here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                buf_data[i]  <= '0;
                buf_index[i] <= '0;
                buf_last[i]  <= 1'b0;
            end
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                buf_data[wr_ptr]  <= bus.do_data;
                buf_index[wr_ptr] <= addr_q;
                buf_last[wr_ptr]  <= (addr_q == LAST_ADDR);
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign bus.addr    = addr_q;
    assign bus.en      = en_q;
    assign bus.we      = 1'b0;
    assign bus.di      = '0;
    assign bus.w_data  = buf_data[rd_ptr];
    assign bus.w_index = buf_index[rd_ptr];
    assign bus.w_last  = buf_last[rd_ptr];
    assign bus.w_valid = (count != 2'd0);
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_weight_stream_reader.sv
// Drives passes over a randomly filled BRAM model and checks the weight stream
// against the expected word sequence mem[0..DEPTH-1].
`timescale 1ns/1ps
module tb_weight_stream_reader;
    localparam int DEPTH = 28;
    localparam int AW    = 5;
    localparam int DW    = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic busy, done;

    weight_stream_reader_if #(.AW(AW), .DW(DW)) bus ();

    weight_stream_reader #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .busy (busy),
        .done (done),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [DEPTH];

    // BRAM with a negedge-registered read port
    always @(negedge clk) begin
        if (bus.en && !bus.we) bus.do_data <= mem[bus.addr];
    end

    typedef struct {
        logic [DW-1:0] data;
        logic [AW-1:0] index;
        logic          last;
        int            c;
    } xfer_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int en_cnt, busy_cnt, outstanding, max_out, stall_viol, we_viol;
    int en_addr_q[$];
    int done_cyc[$];
    xfer_t obs[$];
    logic prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic [AW-1:0] prev_index;
    logic prev_last;

    // Passive recorder sampled mid-cycle; outstanding = reads issued but not yet consumed
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst_n) begin
            if (bus.we !== 1'b0 || bus.di !== '0) we_viol++;
            if (busy) busy_cnt++;
            if (bus.en) begin
                en_cnt++;
                en_addr_q.push_back(int'(bus.addr));
                outstanding++;
                if (outstanding > max_out) max_out = outstanding;
            end
            if (prev_stall && (bus.w_valid !== 1'b1 || bus.w_data !== prev_data ||
                               bus.w_index !== prev_index || bus.w_last !== prev_last))
                stall_viol++;
            if (bus.w_valid && bus.w_ready) begin
                obs.push_back('{bus.w_data, bus.w_index, bus.w_last, cyc});
                outstanding--;
            end
            if (done) done_cyc.push_back(cyc);
            prev_stall = bus.w_valid && !bus.w_ready;
            prev_data  = bus.w_data;
            prev_index = bus.w_index;
            prev_last  = bus.w_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic clear_monitor();
        en_cnt = 0; busy_cnt = 0; outstanding = 0; max_out = 0;
        stall_viol = 0; we_viol = 0;
        en_addr_q.delete(); done_cyc.delete(); obs.delete();
    endtask

    task automatic fill_mem();
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        bus.w_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++;
            $display("[TB] FAIL reset_status got busy %b done %b want 0 0", busy, done); end
        checks++; if (bus.en !== 1'b0 || bus.addr !== '0 || bus.we !== 1'b0 || bus.di !== '0) begin errors++;
            $display("[TB] FAIL reset_bram got en %b addr %0d we %b di %h want 0 0 0 0", bus.en, bus.addr, bus.we, bus.di); end
        checks++; if (bus.w_valid !== 1'b0 || bus.w_data !== '0 || bus.w_last !== 1'b0 || bus.w_index !== '0) begin errors++;
            $display("[TB] FAIL reset_stream got v %b d %h l %b i %0d want 0 0 0 0", bus.w_valid, bus.w_data, bus.w_last, bus.w_index); end
        rst_n = 1'b1;
    endtask

    task automatic test_full_stream();
        int t0;
        int guard;
        fill_mem();
        bus.w_ready = 1'b1;
        @(posedge clk); #1;
        clear_monitor();
        start = 1'b1;
        @(posedge clk); t0 = cyc; #1 start = 1'b0;
        checks++; if (busy !== 1'b1 || bus.en !== 1'b1 || bus.addr !== '0) begin errors++;
            $display("[TB] FAIL full_first_issue got busy %b en %b addr %0d want 1 1 0", busy, bus.en, bus.addr); end
        guard = 0;
        while (done_cyc.size() == 0 && guard < 100) begin @(posedge clk); #1; guard++; end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (obs.size() != DEPTH) begin errors++;
            $display("[TB] FAIL full_count got %0d want %0d", obs.size(), DEPTH); end
        for (int i = 0; i < obs.size() && i < DEPTH; i++) begin
            checks++;
            if (obs[i].index !== AW'(i) || obs[i].data !== mem[i] || obs[i].last !== (i == DEPTH - 1) ||
                obs[i].c != t0 + i + 2) begin errors++;
                $display("[TB] FAIL full_word%0d got i %0d d %h l %b cyc %0d want i %0d d %h l %b cyc %0d",
                         i, obs[i].index, obs[i].data, obs[i].last, obs[i].c - t0, i, mem[i], (i == DEPTH - 1), i + 2);
            end
        end
        checks++; if (en_cnt != DEPTH) begin errors++;
            $display("[TB] FAIL full_reads got %0d want %0d", en_cnt, DEPTH); end
        for (int i = 0; i < en_addr_q.size() && i < DEPTH; i++) begin
            checks++; if (en_addr_q[i] != i) begin errors++;
                $display("[TB] FAIL full_issue_addr%0d got %0d want %0d", i, en_addr_q[i], i); end
        end
        checks++; if (done_cyc.size() != 1 || (done_cyc.size() == 1 && done_cyc[0] != t0 + DEPTH + 2)) begin errors++;
            $display("[TB] FAIL full_done got %0d pulses first at +%0d want 1 at +%0d",
                     done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] - t0 : -1, DEPTH + 2); end
        checks++; if (busy_cnt != DEPTH + 1) begin errors++;
            $display("[TB] FAIL full_busy_cycles got %0d want %0d", busy_cnt, DEPTH + 1); end
        checks++; if (max_out > 2 || we_viol != 0) begin errors++;
            $display("[TB] FAIL full_credit got outstanding %0d we_viol %0d want <=2 0", max_out, we_viol); end
    endtask

    task automatic test_backpressure();
        int guard;
        fill_mem();
        bus.w_ready = 1'b0;
        @(posedge clk); #1;
        clear_monitor();
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++; if (en_cnt != 2 || en_addr_q.size() != 2) begin errors++;
            $display("[TB] FAIL bp_reads got %0d want 2", en_cnt); end
        checks++; if (bus.w_valid !== 1'b1 || bus.w_index !== '0 || bus.w_data !== mem[0] || bus.en !== 1'b0) begin errors++;
            $display("[TB] FAIL bp_head got v %b i %0d d %h en %b want 1 0 %h 0", bus.w_valid, bus.w_index, bus.w_data, mem[0], bus.en); end
        checks++; if (stall_viol != 0) begin errors++;
            $display("[TB] FAIL bp_stable got %0d changes want 0", stall_viol); end
        bus.w_ready = 1'b1;
        guard = 0;
        while (done_cyc.size() == 0 && guard < 100) begin @(posedge clk); #1; guard++; end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (obs.size() != DEPTH || en_cnt != DEPTH) begin errors++;
            $display("[TB] FAIL bp_count got words %0d reads %0d want %0d", obs.size(), en_cnt, DEPTH); end
        for (int i = 0; i < obs.size() && i < DEPTH; i++) begin
            checks++; if (obs[i].index !== AW'(i) || obs[i].data !== mem[i]) begin errors++;
                $display("[TB] FAIL bp_word%0d got i %0d d %h want i %0d d %h", i, obs[i].index, obs[i].data, i, mem[i]); end
        end
        checks++; if (done_cyc.size() != 1 || max_out > 2) begin errors++;
            $display("[TB] FAIL bp_done got pulses %0d outstanding %0d want 1 <=2", done_cyc.size(), max_out); end
    endtask

    // mode 0: ready toggles 1,0,1,0...; mode 1: random ready
    task automatic test_ready_pattern(input int mode);
        int guard;
        fill_mem();
        bus.w_ready = 1'b1;
        @(posedge clk); #1;
        clear_monitor();
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        guard = 0;
        while (done_cyc.size() == 0 && guard < 400) begin
            bus.w_ready = (mode == 0) ? ~bus.w_ready : ($urandom_range(0, 3) != 0);
            @(posedge clk); #1; guard++;
        end
        bus.w_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (obs.size() != DEPTH || en_cnt != DEPTH) begin errors++;
            $display("[TB] FAIL pat%0d_count got words %0d reads %0d want %0d", mode, obs.size(), en_cnt, DEPTH); end
        for (int i = 0; i < obs.size() && i < DEPTH; i++) begin
            checks++; if (obs[i].index !== AW'(i) || obs[i].data !== mem[i] || obs[i].last !== (i == DEPTH - 1)) begin errors++;
                $display("[TB] FAIL pat%0d_word%0d got i %0d d %h l %b want i %0d d %h l %b",
                         mode, i, obs[i].index, obs[i].data, obs[i].last, i, mem[i], (i == DEPTH - 1)); end
        end
        checks++; if (done_cyc.size() != 1) begin errors++;
            $display("[TB] FAIL pat%0d_done got %0d pulses want 1", mode, done_cyc.size()); end
        checks++; if (max_out > 2 || stall_viol != 0) begin errors++;
            $display("[TB] FAIL pat%0d_flow got outstanding %0d stall_changes %0d want <=2 0", mode, max_out, stall_viol); end
    endtask

    task automatic test_abort();
        int guard;
        fill_mem();
        bus.w_ready = 1'b1;
        @(posedge clk); #1;
        clear_monitor();
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        guard = 0;
        while (obs.size() < 11 && guard < 100) begin @(posedge clk); #1; guard++; end
        abort = 1'b1;
        bus.w_ready = 1'b0;
        @(posedge clk); #1 abort = 1'b0;
        checks++; if (busy !== 1'b0 || bus.w_valid !== 1'b0 || bus.en !== 1'b0) begin errors++;
            $display("[TB] FAIL abort_state got busy %b valid %b en %b want 0 0 0", busy, bus.w_valid, bus.en); end
        bus.w_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (done_cyc.size() != 0 || obs.size() != 11) begin errors++;
            $display("[TB] FAIL abort_quiet got done %0d words %0d want 0 11", done_cyc.size(), obs.size()); end
        for (int i = 0; i < obs.size() && i < DEPTH; i++) begin
            checks++; if (obs[i].index !== AW'(i) || obs[i].data !== mem[i]) begin errors++;
                $display("[TB] FAIL abort_word%0d got i %0d d %h want i %0d d %h", i, obs[i].index, obs[i].data, i, mem[i]); end
        end
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        checks++; if (busy !== 1'b0 || bus.en !== 1'b0) begin errors++;
            $display("[TB] FAIL abort_priority got busy %b en %b want 0 0", busy, bus.en); end
        clear_monitor();
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        guard = 0;
        while (done_cyc.size() == 0 && guard < 100) begin @(posedge clk); #1; guard++; end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (obs.size() != DEPTH || (obs.size() > 0 && obs[0].index !== '0) || done_cyc.size() != 1) begin errors++;
            $display("[TB] FAIL abort_restart got words %0d first %0d done %0d want %0d 0 1",
                     obs.size(), (obs.size() > 0) ? int'(obs[0].index) : -1, done_cyc.size(), DEPTH); end
    endtask

    task automatic test_reset_mid_pass();
        int guard;
        fill_mem();
        bus.w_ready = 1'b1;
        @(posedge clk); #1;
        clear_monitor();
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        guard = 0;
        while (!(bus.w_valid === 1'b1 && bus.w_index === AW'(15)) && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        checks++; if (bus.w_index !== AW'(15)) begin errors++;
            $display("[TB] FAIL rst_reach15 got %0d want 15", bus.w_index); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || bus.en !== 1'b0 || bus.addr !== '0) begin errors++;
            $display("[TB] FAIL rst_mid_ctrl got busy %b done %b en %b addr %0d want 0 0 0 0", busy, done, bus.en, bus.addr); end
        checks++; if (bus.w_valid !== 1'b0 || bus.w_data !== '0 || bus.w_last !== 1'b0 || bus.w_index !== '0) begin errors++;
            $display("[TB] FAIL rst_mid_stream got v %b d %h l %b i %0d want 0 0 0 0", bus.w_valid, bus.w_data, bus.w_last, bus.w_index); end
        #1 rst_n = 1'b1;
    endtask

    task automatic test_start_ignored();
        int t0;
        int guard;
        fill_mem();
        bus.w_ready = 1'b1;
        @(posedge clk); #1;
        clear_monitor();
        start = 1'b1;
        @(posedge clk); t0 = cyc; #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        guard = 0;
        while (done !== 1'b1 && guard < 100) begin @(posedge clk); #1; guard++; end
        checks++; if (done !== 1'b1 || cyc - t0 != DEPTH + 1) begin errors++;
            $display("[TB] FAIL ign_done_time got done %b at +%0d want 1 at +%0d", done, cyc - t0, DEPTH + 1); end
        checks++; if (obs.size() != DEPTH || en_cnt != DEPTH) begin errors++;
            $display("[TB] FAIL ign_count got words %0d reads %0d want %0d", obs.size(), en_cnt, DEPTH); end
        start = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || bus.en !== 1'b0) begin errors++;
            $display("[TB] FAIL ign_done_cycle_start got busy %b en %b want 0 0", busy, bus.en); end
        @(posedge clk); #1 start = 1'b0;
        checks++; if (busy !== 1'b1 || bus.en !== 1'b1 || bus.addr !== '0) begin errors++;
            $display("[TB] FAIL ign_after_done_start got busy %b en %b addr %0d want 1 1 0", busy, bus.en, bus.addr); end
        guard = 0;
        while (done !== 1'b1 && guard < 100) begin @(posedge clk); #1; guard++; end
        checks++; if (done !== 1'b1) begin errors++;
            $display("[TB] FAIL ign_second_done got %b want 1", done); end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        bus.w_ready = 1'b0;
        fill_mem();
        test_reset();
        test_full_stream();
        test_backpressure();
        test_ready_pattern(0);
        test_ready_pattern(1);
        test_abort();
        test_reset_mid_pass();
        test_start_ignored();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/weight_stream_reader.md
# weight_stream_reader

Read-side sequencer for one 16-bit weight BRAM (28 words, 5-bit address, negedge-registered read port, write-enable must stay low for reads). On a start pulse it reads every word in order from address 0 and presents them as a valid/ready stream to the neuron MAC datapath. It absorbs MAC backpressure with a 2-entry buffer and sustains one word per cycle when the consumer is always ready. It sits between each per-neuron weight BRAM and its multiply-accumulate unit.

## Interface
- DEPTH, 28, number of weight words read per pass (addresses 0..DEPTH-1)
- AW, 5, BRAM address width
- DW, 16, weight word width
- CLK  in  1  clock; all logic on posedge; the BRAM samples ADDR/EN on negedge
- RST_N  in  1  asynchronous active-low reset
- START  in  1  single-cycle pulse; begins a pass; ignored while BUSY=1
- ABORT  in  1  synchronous; cancels the pass in progress
- BUSY  out  1  high from the cycle after START is accepted until DONE is asserted
- DONE  out  1  one-cycle pulse after the last word is consumed
- ADDR  out  AW  BRAM address
- EN  out  1  BRAM enable; high only in cycles that issue a read
- WE  out  1  BRAM write enable; constant 0
- DI  out  DW  BRAM write data; constant 0
- DO  in  DW  BRAM read data; valid at the posedge after the EN cycle
- W_DATA  out  DW  stream weight
- W_VALID  out  1  stream valid
- W_READY  in  1  consumer ready; transfer when W_VALID and W_READY are both high
- W_LAST  out  1  high with the word from address DEPTH-1
- W_INDEX  out  AW  address the current W_DATA came from

## Operation
- States: IDLE, FETCH, DRAIN.
- IDLE:
  - On START, load the issue counter with 0 and go to FETCH.
  - BUSY goes high at the same edge.
- Issue rule, FETCH only:
  - Credit counter starts at 2 (buffer slots).
  - A read is issued in a cycle (EN=1, ADDR=issue counter) when credit>0, or when a stream pop occurs in that same cycle.
  - Each issue consumes one credit. Each pop returns one credit.
  - Credit never exceeds 2 and never goes below 0.
- In-flight flag: set at the edge that registers EN=1. At the next posedge, DO is written into the buffer together with its address and a last flag (address == DEPTH-1).
- Buffer: 2-entry FIFO.
  - The head drives W_DATA, W_INDEX and W_LAST. W_VALID = not empty.
  - A push and a pop in the same cycle are both performed and occupancy is unchanged.
  - The buffer cannot overflow by construction. The bench asserts this.
- Leaving FETCH: the edge that issues address DEPTH-1 moves the state to DRAIN. No further EN.
- DRAIN: when the W_LAST word pops, go to IDLE, pulse DONE for the next cycle, and drop BUSY at the same edge.
- ABORT, in any state other than IDLE:
  - Next edge: go to IDLE, flush the buffer, clear the in-flight flag, restore credit to 2, deassert EN and BUSY.
  - No DONE pulse.
  - ABORT in IDLE has no effect. ABORT has priority over a same-cycle START.
- START while BUSY=1 is ignored, including in the DONE cycle. START is accepted the cycle after DONE.
- The issue counter stops at DEPTH-1 and does not wrap. It is reloaded only by START.

## Timing
- Reset values: ADDR=0, EN=0, WE=0, DI=0, W_DATA=0, W_VALID=0, W_LAST=0, W_INDEX=0, BUSY=0, DONE=0. State is IDLE, credit is 2, buffer is empty.
- Reset asserted mid-pass behaves like ABORT, but takes effect immediately (asynchronous).
- Read latency: EN/ADDR are registered at edge t. The BRAM reads at the following negedge. The word enters the buffer at t+1, so W_VALID is high in the cycle after t+1.
- START sampled at edge t0:
  - EN=1 with ADDR=0 during the cycle after t0.
  - First W_VALID after t0+1.
- With W_READY held high:
  - Address k is issued after t0+k and popped at t0+k+2.
  - DONE is high in the cycle after t0+DEPTH+1, i.e. 29 cycles after START for DEPTH=28.
  - Throughput is 1 word per cycle.
- W_DATA, W_INDEX and W_LAST are held stable while W_VALID=1 and W_READY=0.

## Test plan
- Reset, then START with W_READY=1 throughout → 28 words in order, W_INDEX 0..27, data equal to the preloaded memory contents, W_LAST only on index 27, DONE at t0+29, BUSY high t0..t0+29.
- W_READY=0 from START for 10 cycles, then 1 → exactly 2 reads issued, then EN stays low and the buffer holds words 0 and 1 stable; the stream then resumes with no loss or duplication.
- W_READY toggling 1,0,1,0 → all 28 words delivered once in order, EN never asserted with credit=0 and no pop, DONE once.
- ABORT after word 10 is popped → next cycle IDLE, W_VALID=0, BUSY=0, no DONE; a following START delivers from index 0 again.
- RST_N low at index 15 → all outputs at reset values immediately; START pulse during BUSY and START in the DONE cycle are ignored; START one cycle after DONE is accepted.
